clk_div_prog: RTL and testbench

- Parametrised, runtime-programmable successor to the fixed-ratio clock divider.
- Generates a divided square wave plus a one-cycle tick strobe from CLK, with an enable and a glitch-free divisor update applied only at period boundaries.
- Feeds the BLDC commutation/PWM timing blocks, which need retunable rates without output glitches.

---
 rtl/clk_div_prog.sv | 114 +++++++++++
 tb/tb_clk_div_prog.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider: divided square wave plus a per-period tick.
// Divisor updates are deferred to period boundaries so no period mixes rates.
module clk_div_prog #(
   parameter int WIDTH       = 16,
   parameter int DIV_DEFAULT = 2002
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [WIDTH-1:0] DIV_IN,
   input  logic             DIV_LOAD,
   output logic             DIV_BUSY,
   output logic             DIV_ERR,
   output logic             CLK_out,
   output logic             TICK
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
   localparam logic [WIDTH-1:0] DEFV = WIDTH'(DIV_DEFAULT);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;

   logic [WIDTH-1:0] half;
   logic             last;
   logic             mid;
   logic             ld_ok;
   logic             ld_bad;

   // Period decode: low phase is ceil(D/2) cycles, boundary at D-1.
   always_comb begin
      half   = div_q - (div_q >> 1);
      last   = (cnt_q == div_q - ONE);
      mid    = (cnt_q == half - ONE);
      ld_bad = DIV_LOAD && (DIV_IN < TWO);
      ld_ok  = DIV_LOAD && (DIV_IN >= TWO);
   end

   // Counter and output waveform generation.
   always_comb begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      if (EN) begin
         if (last) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
            clk_d = mid ? 1'b1 : clk_q;
         end
      end
   end

   // Divisor bookkeeping: pending value swaps in only at a boundary or idle.
   always_comb begin
      div_d  = div_q;
      pend_d = pend_q;
      busy_d = busy_q;
      err_d  = ld_bad;
      if (EN) begin
         if (last && busy_q) begin
            div_d  = pend_q;
            busy_d = 1'b0;
         end
         if (ld_ok) begin
            pend_d = DIV_IN;
            busy_d = 1'b1;
         end
      end else begin
         if (busy_q) begin
            div_d  = pend_q;
            busy_d = 1'b0;
         end
         if (ld_ok) begin
            div_d = DIV_IN;
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q  <= '0;
         div_q  <= DEFV;
         pend_q <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
         err_q  <= err_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign DIV_BUSY = busy_q;
   assign DIV_ERR  = err_q;
   assign CLK_out  = clk_q;
   assign TICK     = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: period-position reference model with
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_clk_div_prog;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] din = '0;
   logic        DIV_BUSY, DIV_ERR, CLK_out, TICK;

   int n_pass = 0;
   int n_tot  = 0;

   // reference model state: current divisor, position in period
   int m_d = 2002;
   int m_pend = 0;
   int m_pos = 0;
   bit m_busy = 0;
   bit m_err = 0;
   bit m_tick = 0;

   clk_div_prog dut (
      .CLK      (clk),
      .RST      (rst),
      .EN       (en),
      .DIV_IN   (din),
      .DIV_LOAD (load),
      .DIV_BUSY (DIV_BUSY),
      .DIV_ERR  (DIV_ERR),
      .CLK_out  (CLK_out),
      .TICK     (TICK)
   );

   always #5 clk = ~clk;

   task automatic check(string name, int act, int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                    name, act, exp, $time);
   endtask

   // model advances on each edge, DUT compared just after it
   always @(posedge clk) begin
      bit ok;
      ok = load && (din >= 2);
      if (rst) begin
         m_d = 2002; m_busy = 0; m_pos = 0;
         m_tick = 0; m_err = 0;
      end else begin
         m_err = load && (din < 2);
         m_tick = 0;
         if (en) begin
            if (m_pos == m_d - 1) begin
               m_pos = 0;
               m_tick = 1;
               if (m_busy) begin
                  m_d = m_pend;
                  m_busy = 0;
               end
            end else begin
               m_pos = m_pos + 1;
            end
            if (ok) begin
               m_pend = int'(din);
               m_busy = 1;
            end
         end else begin
            m_pos = 0;
            if (m_busy) m_d = m_pend;
            m_busy = 0;
            if (ok) m_d = int'(din);
         end
      end
      #1;
      check("clk_out", int'(CLK_out),
            int'(m_pos >= (m_d + 1) / 2));
      check("tick", int'(TICK), int'(m_tick));
      check("busy", int'(DIV_BUSY), int'(m_busy));
      check("err", int'(DIV_ERR), int'(m_err));
   end

   task automatic cyc(bit r, bit e, bit l, int d);
      @(negedge clk);
      rst = r;
      en = e;
      load = l;
      din = d[15:0];
      @(posedge clk);
      #2;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc(0, 1, 0, 0);
         n++;
      end while (!TICK && n < 5000);
   endtask

   initial begin
      int n, hi, cv, tv;
      repeat (3) cyc(1, 0, 0, 0);
      check("rst_clk", int'(CLK_out), 0);
      check("rst_busy", int'(DIV_BUSY), 0);

      // default divisor: 2002 period, 1001 high
      n = 0; hi = 0;
      do begin
         cyc(0, 1, 0, 0);
         n++;
         if (CLK_out) hi++;
      end while (!TICK && n < 5000);
      check("def_period", n, 2002);
      check("def_high", hi, 1001);

      // odd divisor 5 from idle
      cyc(0, 0, 1, 5);
      cv = 0; tv = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 0, 0);
         if (CLK_out) cv |= (1 << i);
         if (TICK) tv |= (1 << i);
      end
      check("odd_clk_pat", cv, 396);
      check("odd_tick_pat", tv, 528);

      // deferred update 10 -> 4
      cyc(0, 0, 1, 10);
      repeat (3) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 4);
      check("defer_busy", int'(DIV_BUSY), 1);
      wait_tick(n);
      check("defer_old", 4 + n, 10);
      check("defer_clear", int'(DIV_BUSY), 0);
      wait_tick(n);
      check("defer_new", n, 4);

      // invalid loads at D=4
      cyc(0, 1, 1, 1);
      check("err1", int'(DIV_ERR), 1);
      cyc(0, 1, 0, 0);
      check("err_pulse", int'(DIV_ERR), 0);
      cyc(0, 1, 1, 0);
      check("err0", int'(DIV_ERR), 1);
      wait_tick(n);
      check("err_keep", 3 + n, 4);
      wait_tick(n);
      check("err_keep2", n, 4);

      // load on boundary while 8 pending
      cyc(0, 1, 1, 8);
      repeat (2) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 6);
      check("coll_tick", int'(TICK), 1);
      check("coll_busy", int'(DIV_BUSY), 1);
      wait_tick(n);
      check("coll_p8", n, 8);
      wait_tick(n);
      check("coll_p6", n, 6);

      // last write wins
      cyc(0, 1, 1, 7);
      cyc(0, 1, 1, 3);
      wait_tick(n);
      check("lww_cur", 2 + n, 6);
      wait_tick(n);
      check("lww_p3", n, 3);

      // EN drop mid-period
      cyc(0, 0, 1, 10);
      repeat (2) cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      check("en_drop_clk", int'(CLK_out), 0);
      check("en_drop_tick", int'(TICK), 0);
      wait_tick(n);
      check("en_restart", n, 10);

      // reset while pending
      cyc(0, 1, 1, 4);
      check("rstp_busy1", int'(DIV_BUSY), 1);
      cyc(1, 1, 0, 0);
      check("rstp_busy0", int'(DIV_BUSY), 0);
      wait_tick(n);
      check("rstp_period", n, 2002);

      // randomized traffic
      for (int i = 0; i < 8000; i++) begin
         cyc($urandom_range(0, 999) == 0,
             $urandom_range(0, 15) != 0,
             $urandom_range(0, 4) == 0,
             int'($urandom_range(0, 11)));
      end

      cyc(0, 0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
